sam_bus_memory: RTL and testbench

Synthesizable memory responder for the SAM CPU's shared memory bus. It answers the CPU's `En`/`Rw`/`Address_Bus`/`Data_Bus` transactions from an internal byte array. It also owns a byte-serial program loader that fills the array and holds the CPU off the bus until loading completes. It sits beside `Toplevel` in the FPGA top and replaces the behavioural memory used in simulation.

---
 rtl/sam_pkg.sv | 13 +
 rtl/sam_mem_array.sv | 37 +++
 rtl/sam_bus_memory.sv | 147 ++++++++++++++
 tb/tb_sam_bus_memory.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sam_pkg.sv
// Shared SAM definitions: memory responder FSM states and default bus geometry.
package sam_pkg;

    localparam int unsigned SAM_AW        = 8;
    localparam int unsigned SAM_DW        = 8;
    localparam int unsigned SAM_MEM_DEPTH = 64;

    typedef enum logic {
        MEM_LOAD = 1'b0,
        MEM_RUN  = 1'b1
    } mem_state_t;

endpackage

// File: rtl/sam_mem_array.sv
// Single-port byte RAM: synchronous write, registered read with a zero-fill option
// used for out-of-range reads. Only the read register is reset; the array is not.
module sam_mem_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DW    = 8,
    parameter int unsigned IW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic          i_re,
    input  logic          i_re_zero,
    input  logic [IW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd <= '0;
        end else if (i_re) begin
            r_rd <= i_re_zero ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rd;

endmodule

// File: rtl/sam_bus_memory.sv
// SAM shared-bus memory responder with byte-serial program loader and CPU hold.
// Define SAM_MEM_STATS_EN to add saturating in-range read/write counters.
module sam_bus_memory
    import sam_pkg::*;
#(
    parameter int unsigned DEPTH = SAM_MEM_DEPTH,
    parameter int unsigned AW    = SAM_AW,
    parameter int unsigned DW    = SAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          En,
    input  logic          Rw,
    input  logic [AW-1:0] Address_Bus,
    inout  wire  [DW-1:0] Data_Bus,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic          cpu_hold,
    output logic          range_err
`ifdef SAM_MEM_STATS_EN
    ,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count
`endif
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**AW does not wrap to zero.
    localparam logic [AW:0] ADDR_LIMIT = (AW + 1)'(DEPTH);

    mem_state_t    r_state, w_state_next;
    logic [IW-1:0] r_ptr, w_ptr_next;
    logic          r_drive;
    logic          r_range_err;

    logic          w_run;
    logic          w_in_range;
    logic          w_load_acc;
    logic          w_bus_rd;
    logic          w_bus_wr;
    logic          w_arr_we;
    logic [IW-1:0] w_arr_addr;
    logic [DW-1:0] w_arr_wdata;
    logic [DW-1:0] w_rd_data;

    assign w_run      = (r_state == MEM_RUN);
    assign w_in_range = ({1'b0, Address_Bus} < ADDR_LIMIT);
    assign w_load_acc = !w_run && load_valid;
    assign w_bus_rd   = w_run && En && Rw;
    assign w_bus_wr   = w_run && En && !Rw;

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        load_ready   = 1'b0;
        cpu_hold     = 1'b0;
        unique case (r_state)
            MEM_LOAD: begin
                load_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (load_valid) begin
                    w_ptr_next = r_ptr + IW'(1);
                    if (load_last || (r_ptr == IW'(DEPTH - 1))) begin
                        w_state_next = MEM_RUN;
                    end
                end
            end
            MEM_RUN: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MEM_LOAD;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Write drops out-of-range bus addresses; reads still respond (with zero).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drive     <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            if (w_bus_rd) begin
                r_drive <= 1'b1;
            end else if (w_bus_wr) begin
                r_drive <= 1'b0;
            end
            if (w_run && En && !w_in_range) begin
                r_range_err <= 1'b1;
            end
        end
    end

    assign w_arr_we    = w_load_acc || (w_bus_wr && w_in_range);
    assign w_arr_addr  = w_run ? Address_Bus[IW-1:0] : r_ptr;
    assign w_arr_wdata = w_run ? Data_Bus : load_data;

    sam_mem_array #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .IW    (IW)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_arr_we),
        .i_re      (w_bus_rd),
        .i_re_zero (!w_in_range),
        .i_addr    (w_arr_addr),
        .i_wdata   (w_arr_wdata),
        .o_rdata   (w_rd_data)
    );

    // Rw gating releases the bus in the very cycle the CPU turns around to write.
    assign Data_Bus  = (r_drive && Rw) ? w_rd_data : {DW{1'bz}};
    assign range_err = r_range_err;

`ifdef SAM_MEM_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_bus_rd && w_in_range && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_bus_wr && w_in_range && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_sam_bus_memory.sv
// Self-checking bench for sam_bus_memory: directed loader/bus sequences, a vector
// table, and randomized bus traffic against a behavioural memory model.
module tb_sam_bus_memory;

    logic       clk;
    logic       rst;
    logic       En;
    logic       Rw;
    logic [7:0] Address_Bus;
    wire  [7:0] Data_Bus;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       cpu_hold;
    logic       range_err;
`ifdef SAM_MEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    logic       tb_oe;
    logic [7:0] tb_drv;
    assign Data_Bus = tb_oe ? tb_drv : 8'bz;

    sam_bus_memory dut (
        .clk         (clk),
        .rst         (rst),
        .En          (En),
        .Rw          (Rw),
        .Address_Bus (Address_Bus),
        .Data_Bus    (Data_Bus),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_hold    (cpu_hold),
        .range_err   (range_err)
`ifdef SAM_MEM_STATS_EN
        ,
        .rd_count    (rd_count),
        .wr_count    (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the bus-visible state.
    logic [7:0] m_mem [64];
    logic [7:0] m_rd;
    bit         m_drive;
    bit         m_err;
    int         m_rdc;
    int         m_wrc;

    typedef struct {
        logic       en;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
        logic       chk;
        logic [7:0] exp_bus;
        logic       exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        En          = 1'b0;
        Rw          = 1'b1;
        Address_Bus = 8'h00;
        load_valid  = 1'b0;
        load_data   = 8'h00;
        load_last   = 1'b0;
        tb_oe       = 1'b0;
        tb_drv      = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset load_ready", load_ready, 1);
        check("reset cpu_hold", cpu_hold, 1);
        check("reset range_err", range_err, 0);
`ifdef SAM_MEM_STATS_EN
        check("reset rd_count", rd_count, 0);
        check("reset wr_count", wr_count, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_drive = 0;
        m_rd    = 8'h00;
        m_err   = 0;
        m_rdc   = 0;
        m_wrc   = 0;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // One bus cycle in RUN, checked against the model after the edge.
    task automatic mop(input logic en, input logic rw, input logic [7:0] addr,
                       input logic [7:0] data);
        En          = en;
        Rw          = rw;
        Address_Bus = addr;
        tb_drv      = data;
        tb_oe       = !rw;
        @(posedge clk);
        #1;
        if (en) begin
            if (addr >= 8'd64) begin
                m_err = 1;
                if (rw) begin
                    m_rd    = 8'h00;
                    m_drive = 1;
                end else begin
                    m_drive = 0;
                end
            end else if (rw) begin
                m_rd    = m_mem[addr];
                m_drive = 1;
                m_rdc++;
            end else begin
                m_mem[addr] = data;
                m_drive     = 0;
                m_wrc++;
            end
        end
        if (!rw) begin
            check("bus free on write", Data_Bus, data);
        end else if (m_drive) begin
            check($sformatf("read a=%0h", addr), Data_Bus, m_rd);
        end
        check("range_err", range_err, m_err);
        check("cpu_hold in run", cpu_hold, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h17, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h07, 8'hFD, 1'b1, 8'hFD, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'h07, 8'h00, 1'b1, 8'hFD, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'hFD, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 8'h02, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h02, 8'h3C, 1'b1, 8'h3C, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 8'h02, 8'h00, 1'b1, 8'h3C, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 8'h40, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 8'h40, 8'h55, 1'b1, 8'h55, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h17, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};

        // Short program with load_last on the third byte.
        do_reset();
        load_byte(8'h17, 1'b0);
        check("short hold b0", cpu_hold, 1);
        load_byte(8'h61, 1'b0);
        check("short hold b1", cpu_hold, 1);
        load_byte(8'h01, 1'b1);
        check("short hold after last", cpu_hold, 0);
        check("short ready after last", load_ready, 0);
        m_mem[0] = 8'h17;
        m_mem[1] = 8'h61;
        m_mem[2] = 8'h01;
        mop(1'b1, 1'b1, 8'h01, 8'h00);

        for (int i = 0; i < 12; i++) begin
            En          = vecs[i].en;
            Rw          = vecs[i].rw;
            Address_Bus = vecs[i].addr;
            tb_drv      = vecs[i].data;
            tb_oe       = !vecs[i].rw;
            @(posedge clk);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d bus", i), Data_Bus, vecs[i].exp_bus);
            end
            check($sformatf("vec%0d range_err", i), range_err, vecs[i].exp_err);
        end

        // Asynchronous reset from RUN reasserts the hold before any edge.
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        check("async hold", cpu_hold, 1);
        check("async ready", load_ready, 1);
        check("async range_err clr", range_err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-load restarts the pointer at zero.
        for (int i = 0; i < 5; i++) begin
            load_byte(8'h11 + 8'(i), 1'b0);
            check("midload hold", cpu_hold, 1);
        end
        do_reset();
        check("reload hold", cpu_hold, 1);
        load_byte(8'hAA, 1'b1);
        check("reload run", cpu_hold, 0);
        m_mem[0] = 8'hAA;
        mop(1'b1, 1'b1, 8'h00, 8'h00);

        // Full load without load_last.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            m_mem[i] = 8'($urandom);
            load_byte(m_mem[i], 1'b0);
            check($sformatf("full hold b%0d", i), cpu_hold, (i < 63) ? 1 : 0);
            check($sformatf("full ready b%0d", i), load_ready, (i < 63) ? 1 : 0);
        end

        mop(1'b1, 1'b1, 8'h01, 8'h00);
        mop(1'b1, 1'b1, 8'h02, 8'h00);
        mop(1'b1, 1'b1, 8'h03, 8'h00);
        mop(1'b1, 1'b0, 8'h04, 8'h5C);
        mop(1'b1, 1'b0, 8'h05, 8'hA3);
        mop(1'b1, 1'b1, 8'h41, 8'h00);
`ifdef SAM_MEM_STATS_EN
        check("stats rd_count", rd_count, 3);
        check("stats wr_count", wr_count, 2);
`endif

        // A 65th loader byte in RUN must not land anywhere.
        load_byte(~m_mem[0], 1'b0);
        check("65th ready", load_ready, 0);
        mop(1'b1, 1'b1, 8'h00, 8'h00);

        for (int i = 0; i < 400; i++) begin
            mop(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 79)), 8'($urandom));
        end
`ifdef SAM_MEM_STATS_EN
        check("rand rd_count", rd_count, m_rdc);
        check("rand wr_count", wr_count, m_wrc);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
